// File: rtl/bus_arbiter_pkg.sv
// Shared types and defaults for the two-master memory bus arbiter.
package bus_arbiter_pkg;

    // Arbiter FSM states: idle/arbitrating, fetch transaction, data transaction.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INSTR = 2'd1,
        DATA  = 2'd2
    } arb_state_t;

    // Which master owns the current transaction.
    typedef enum logic {
        OWNER_INSTR = 1'b0,
        OWNER_DATA  = 1'b1
    } owner_t;

    localparam int DEFAULT_STARVE_LIMIT = 4;
    localparam int DEFAULT_TIMEOUT      = 255;

endpackage

// File: rtl/arb_watchdog.sv
// Response watchdog: loaded on every grant, counts down once per busy cycle
// and flags expiry on the TIMEOUT-th busy cycle of a transaction.
module arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic active,
    output logic expired
);

    localparam int            CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    // Reload at the grant edge, then count down until zero while busy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (start) begin
            count <= LOAD;
        end else if (active && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

    // First busy cycle sees TIMEOUT-1, so zero is reached on busy cycle TIMEOUT.
    assign expired = active && (count == '0);

endmodule

// File: rtl/memory_bus_arbiter.sv
// Two-master (fetch / data) arbiter for one memory port. Data has fixed
// priority, fetch is protected by a starvation counter, and a watchdog
// aborts hung transactions and raises a sticky bus_error.
module memory_bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
    parameter int TIMEOUT      = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instruction_request,
    input  logic [31:0] instruction_address,
    output logic [31:0] instruction_data,
    output logic        instruction_response,
    input  logic        data_memory_read,
    input  logic        data_memory_write,
    input  logic [31:0] data_address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        data_memory_response,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    input  logic        mem_response,
    output logic        bus_error
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    arb_state_t  state, state_next;
    owner_t      owner;
    logic [3:0]  starve_count, starve_next;
    logic        mem_read_next, mem_write_next;
    logic [31:0] address_next, write_data_next;
    logic        bus_error_next;

    logic busy;
    logic data_wanted;
    logic starved;
    logic grant_data;
    logic grant_instr;
    logic expired;
    logic timed_out;
    logic done;

    assign busy      = (state != IDLE);
    assign owner     = (state == DATA) ? OWNER_DATA : OWNER_INSTR;
    assign timed_out = expired && !mem_response;
    assign done      = busy && (mem_response || expired);

    // Data wins arbitration unless fetch has waited out its starvation budget.
    assign data_wanted = data_memory_read || data_memory_write;
    assign starved     = instruction_request && (starve_count == STARVE_MAX);
    assign grant_data  = !busy && data_wanted && !starved;
    assign grant_instr = !busy && instruction_request && !grant_data;

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .start   (grant_data || grant_instr),
        .active  (busy),
        .expired (expired)
    );

    // Next state, registered strobes/latches, starve counter and error flag.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_next      = state;
        mem_read_next   = mem_read;
        mem_write_next  = mem_write;
        address_next    = mem_address;
        write_data_next = mem_write_data;
        starve_next     = starve_count;
        bus_error_next  = bus_error;

        case (state)
            IDLE: begin
                if (!instruction_request) begin
                    starve_next = '0;
                end
                if (grant_data) begin
                    state_next      = DATA;
                    mem_write_next  = data_memory_write;
                    mem_read_next   = !data_memory_write;
                    address_next    = data_address;
                    write_data_next = write_data;
                    if (instruction_request && (starve_count != STARVE_MAX)) begin
                        starve_next = starve_count + 4'd1;
                    end
                end else if (grant_instr) begin
                    state_next     = INSTR;
                    mem_read_next  = 1'b1;
                    mem_write_next = 1'b0;
                    address_next   = instruction_address;
                    starve_next    = '0;
                end
            end
            INSTR, DATA: begin
                if (done) begin
                    state_next     = IDLE;
                    mem_read_next  = 1'b0;
                    mem_write_next = 1'b0;
                    if (timed_out) begin
                        bus_error_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next     = IDLE;
                mem_read_next  = 1'b0;
                mem_write_next = 1'b0;
            end
        endcase
    end

    // State register and registered memory-side outputs.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            state          <= IDLE;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
            starve_count   <= '0;
            bus_error      <= 1'b0;
        end else begin
            state          <= state_next;
            mem_read       <= mem_read_next;
            mem_write      <= mem_write_next;
            mem_address    <= address_next;
            mem_write_data <= write_data_next;
            starve_count   <= starve_next;
            bus_error      <= bus_error_next;
        end
    end

    // Responses go straight through to the owner; a watchdog abort zeroes its data.
    assign instruction_response = done && (owner == OWNER_INSTR);
    assign data_memory_response = done && (owner == OWNER_DATA);
    assign instruction_data     = (timed_out && (owner == OWNER_INSTR)) ? '0 : mem_read_data;
    assign read_data            = (timed_out && (owner == OWNER_DATA))  ? '0 : mem_read_data;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Self-checking bench for memory_bus_arbiter: directed scenarios followed by
// randomized traffic, all compared against a transaction-rule model.
module tb_memory_bus_arbiter;

    localparam int STARVE_P  = 4;
    localparam int TIMEOUT_P = 8;

    logic        clk;
    logic        reset;
    logic        instruction_request;
    logic [31:0] instruction_address;
    logic [31:0] instruction_data;
    logic        instruction_response;
    logic        data_memory_read;
    logic        data_memory_write;
    logic [31:0] data_address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        data_memory_response;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        mem_response;
    logic        bus_error;

    memory_bus_arbiter #(
        .STARVE_LIMIT (STARVE_P),
        .TIMEOUT      (TIMEOUT_P)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .instruction_request  (instruction_request),
        .instruction_address  (instruction_address),
        .instruction_data     (instruction_data),
        .instruction_response (instruction_response),
        .data_memory_read     (data_memory_read),
        .data_memory_write    (data_memory_write),
        .data_address         (data_address),
        .write_data           (write_data),
        .read_data            (read_data),
        .data_memory_response (data_memory_response),
        .mem_read             (mem_read),
        .mem_write            (mem_write),
        .mem_address          (mem_address),
        .mem_write_data       (mem_write_data),
        .mem_read_data        (mem_read_data),
        .mem_response         (mem_response),
        .bus_error            (bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model: one outstanding transaction, its owner, its age in
    // cycles, what was latched at grant, the fetch wait count and the error flag.
    bit          m_busy;
    bit          m_is_data;
    bit          m_write;
    int          m_age;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    int          m_starve;
    bit          m_error;
    string       resp_log;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        m_busy   = 1'b0;
        m_is_data = 1'b0;
        m_write  = 1'b0;
        m_age    = 0;
        m_starve = 0;
        m_error  = 1'b0;
    endtask

    // Compare every output against what the rules predict for this cycle.
    task automatic compare_outputs();
        bit timeout;
        bit done;
        timeout = m_busy && !mem_response && (m_age == TIMEOUT_P);
        done    = m_busy && (mem_response || timeout);
        if (instruction_response) resp_log = {resp_log, "I"};
        if (data_memory_response) resp_log = {resp_log, "D"};
        check("instruction_response", 32'(instruction_response), 32'(done && !m_is_data));
        check("data_memory_response", 32'(data_memory_response), 32'(done && m_is_data));
        check("instruction_data", instruction_data, (timeout && !m_is_data) ? 32'h0 : mem_read_data);
        check("read_data", read_data, (timeout && m_is_data) ? 32'h0 : mem_read_data);
        check("mem_read", 32'(mem_read), 32'(m_busy && !m_write));
        check("mem_write", 32'(mem_write), 32'(m_busy && m_write));
        check("bus_error", 32'(bus_error), 32'(m_error));
        if (m_busy) begin
            check("mem_address", mem_address, m_addr);
            if (m_write) check("mem_write_data", mem_write_data, m_wdata);
        end
    endtask

    // Apply the arbitration rules for the coming rising edge.
    task automatic advance_model();
        bit timeout;
        bit dreq;
        timeout = m_busy && !mem_response && (m_age == TIMEOUT_P);
        if (m_busy) begin
            if (mem_response || timeout) begin
                m_busy = 1'b0;
                if (timeout) m_error = 1'b1;
            end else begin
                m_age++;
            end
        end else begin
            dreq = data_memory_read || data_memory_write;
            if (dreq && !(instruction_request && m_starve >= STARVE_P)) begin
                m_busy    = 1'b1;
                m_is_data = 1'b1;
                m_write   = data_memory_write;
                m_addr    = data_address;
                m_wdata   = write_data;
                m_age     = 1;
                if (instruction_request && m_starve < STARVE_P) m_starve++;
            end else if (instruction_request) begin
                m_busy    = 1'b1;
                m_is_data = 1'b0;
                m_write   = 1'b0;
                m_addr    = instruction_address;
                m_age     = 1;
                m_starve  = 0;
            end
            if (!instruction_request) m_starve = 0;
        end
    endtask

    // One clock: sample at the falling edge, step the model, return just after the rise.
    task automatic cycle();
        @(negedge clk);
        compare_outputs();
        advance_model();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        instruction_request = 1'b0;
        data_memory_read    = 1'b0;
        data_memory_write   = 1'b0;
        mem_response        = 1'b0;
    endtask

    initial begin
        idle_inputs();
        instruction_address = 32'h0;
        data_address        = 32'h0;
        write_data          = 32'h0;
        mem_read_data       = 32'h0;
        resp_log            = "";
        model_reset();

        // Reset values.
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        check("reset mem_read", 32'(mem_read), 32'h0);
        check("reset mem_write", 32'(mem_write), 32'h0);
        check("reset mem_address", mem_address, 32'h0);
        check("reset mem_write_data", mem_write_data, 32'h0);
        check("reset bus_error", 32'(bus_error), 32'h0);
        check("reset instruction_response", 32'(instruction_response), 32'h0);
        check("reset data_memory_response", 32'(data_memory_response), 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;
        cycle();

        // Single data load answered 3 cycles after the grant edge.
        data_memory_read = 1'b1;
        data_address     = 32'h100;
        cycle();
        data_memory_read = 1'b0;
        data_address     = 32'hFFFF_0000;
        #1;
        check("load mem_read", 32'(mem_read), 32'h1);
        check("load mem_address", mem_address, 32'h100);
        cycle();
        cycle();
        mem_response  = 1'b1;
        mem_read_data = 32'hDEAD_BEEF;
        #1;
        check("load data_memory_response", 32'(data_memory_response), 32'h1);
        check("load read_data", read_data, 32'hDEAD_BEEF);
        check("load instruction_response", 32'(instruction_response), 32'h0);
        cycle();
        idle_inputs();
        cycle();

        // Fetch during a stream of stores, memory answering in one cycle.
        resp_log            = "";
        data_memory_write   = 1'b1;
        instruction_request = 1'b1;
        instruction_address = 32'h0000_4000;
        for (int i = 0; i < 14; i++) begin
            data_address = 32'h2000 + 32'(i * 4);
            write_data   = 32'hC0DE_0000 + 32'(i);
            mem_response = m_busy;
            cycle();
        end
        idle_inputs();
        cycle();
        n_compared++;
        assert (resp_log == "DDDDIDD") else begin
            n_mismatched++;
            $error("FAIL starve order: observed %s expected DDDDIDD", resp_log);
        end

        // Read and write asserted together is a write.
        data_memory_read  = 1'b1;
        data_memory_write = 1'b1;
        data_address      = 32'h200;
        write_data        = 32'hA5A5_5A5A;
        cycle();
        idle_inputs();
        #1;
        check("rw mem_write", 32'(mem_write), 32'h1);
        check("rw mem_read", 32'(mem_read), 32'h0);
        check("rw mem_write_data", mem_write_data, 32'hA5A5_5A5A);
        mem_response = 1'b1;
        cycle();
        mem_response = 1'b0;
        cycle();

        // Hung memory: abort on busy cycle TIMEOUT with zero data.
        data_memory_read = 1'b1;
        data_address     = 32'h300;
        mem_read_data    = 32'h1234_5678;
        cycle();
        data_memory_read = 1'b0;
        for (int i = 1; i <= TIMEOUT_P; i++) begin
            #1;
            check("hang data_memory_response", 32'(data_memory_response), 32'(i == TIMEOUT_P));
            check("hang read_data", read_data, (i == TIMEOUT_P) ? 32'h0 : 32'h1234_5678);
            cycle();
        end
        check("hang bus_error set", 32'(bus_error), 32'h1);
        instruction_request = 1'b1;
        instruction_address = 32'h400;
        cycle();
        instruction_request = 1'b0;
        #1;
        check("post-hang mem_read", 32'(mem_read), 32'h1);
        check("post-hang mem_address", mem_address, 32'h400);
        mem_response = 1'b1;
        cycle();
        mem_response = 1'b0;
        cycle();
        check("bus_error sticky", 32'(bus_error), 32'h1);

        // Asynchronous reset in the middle of a store.
        data_memory_write = 1'b1;
        data_address      = 32'h500;
        write_data        = 32'h0BAD_F00D;
        cycle();
        reset = 1'b0;
        #1;
        mem_response = 1'b1;
        #1;
        check("midreset mem_write", 32'(mem_write), 32'h0);
        check("midreset mem_read", 32'(mem_read), 32'h0);
        check("midreset data_memory_response", 32'(data_memory_response), 32'h0);
        check("midreset instruction_response", 32'(instruction_response), 32'h0);
        check("midreset bus_error cleared", 32'(bus_error), 32'h0);
        idle_inputs();
        @(posedge clk);
        #1 reset = 1'b1;
        model_reset();
        cycle();

        // Spurious memory response while idle.
        mem_response = 1'b1;
        #1;
        check("spurious data_memory_response", 32'(data_memory_response), 32'h0);
        check("spurious instruction_response", 32'(instruction_response), 32'h0);
        cycle();
        mem_response = 1'b0;
        #1;
        check("spurious stays idle", 32'(mem_read | mem_write), 32'h0);
        cycle();

        // Randomized traffic, including spurious responses and occasional timeouts.
        for (int i = 0; i < 3000; i++) begin
            instruction_request = ($urandom_range(0, 1) == 0);
            data_memory_read    = ($urandom_range(0, 2) == 0);
            data_memory_write   = ($urandom_range(0, 3) == 0);
            instruction_address = $urandom;
            data_address        = $urandom;
            write_data          = $urandom;
            mem_read_data       = $urandom;
            mem_response        = ($urandom_range(0, 2) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/memory_bus_arbiter.md
# memory_bus_arbiter

Two-master, one-slave arbiter that shares a single memory port between the core's instruction-fetch bus and data bus. It sits between `Grande_Risco5` and the unified memory. Data accesses have fixed priority, with a starvation guard for fetch and a response watchdog that ends hung transactions with a sticky error flag. Grants are exclusive, one transaction per grant, and the arbiter returns to arbitration after every completion.

## Interface
- `STARVE_LIMIT`, default 4: consecutive data grants allowed while fetch waits; range 1–15.
- `TIMEOUT`, default 255: cycles a granted transaction may wait for `mem_response` before abort; range 1–65535.
- `clk` in 1: single clock; everything is on its rising edge.
- `reset` in 1: asynchronous, active-low; async assert, sync deassert upstream.
- `instruction_request` in 1: fetch wants a word; level signal.
- `instruction_address` in 32: fetch address.
- `instruction_data` out 32: `mem_read_data` passthrough.
- `instruction_response` out 1: fetch done; one-cycle pulse.
- `data_memory_read` in 1: load request; level signal.
- `data_memory_write` in 1: store request; level signal.
- `data_address` in 32: data address.
- `write_data` in 32: store data.
- `read_data` out 32: `mem_read_data` passthrough.
- `data_memory_response` out 1: data done; one-cycle pulse.
- `mem_read` out 1: registered read strobe to memory.
- `mem_write` out 1: registered write strobe to memory.
- `mem_address` out 32: registered address to memory.
- `mem_write_data` out 32: registered store data to memory.
- `mem_read_data` in 32: memory read data.
- `mem_response` in 1: memory completion; one cycle.
- `bus_error` out 1: sticky; set on watchdog expiry, cleared only by reset.

## Operation
- **States:** `IDLE`, `INSTR`, `DATA`.
- **Reset values:**
  - state `IDLE`
  - `mem_read`, `mem_write`, `mem_address`, `mem_write_data` = 0
  - starve counter 0, watchdog 0
  - `bus_error` 0
  - both responses 0
- **`IDLE`, data request present** (`data_memory_read` or `data_memory_write`):
  - Grant data unless starve counter == `STARVE_LIMIT` and `instruction_request` = 1.
  - On a data grant, latch `data_address` and `write_data`.
  - Set `mem_write` if `data_memory_write`, else `mem_read`. If both are asserted, treat it as a write.
  - Go to `DATA`.
- **`IDLE`, fetch request:** otherwise, if `instruction_request`, latch `instruction_address`, set `mem_read`, go to `INSTR`.
- **Starve counter:**
  - Increments (saturating) on each data grant made while `instruction_request` = 1.
  - Clears on every instruction grant.
  - Clears whenever `instruction_request` = 0 in `IDLE`.
- **`INSTR` / `DATA`:**
  - Hold the strobe and latched address/data constant.
  - Ignore master-side changes.
  - When `mem_response` = 1:
    - drop strobes next edge;
    - return to `IDLE`;
    - assert the owner's response combinationally in that same cycle (`owner && mem_response`).
- **Watchdog:**
  - Counts cycles in `INSTR`/`DATA`; cleared on entry.
  - Reaching `TIMEOUT` without a response:
    - pulse the owner's response with its data output forced to 0 that cycle;
    - set `bus_error`;
    - drop strobes;
    - go to `IDLE`.
- **Non-owner outputs:** the non-owner's response is always 0. The data passthroughs are ungated, so consumers qualify them with their response.
- **Spurious response:** `mem_response` in `IDLE` is ignored, with no response pulse.

## Timing
- **Request to memory:**
  - Request seen at edge N → strobe/address valid after edge N (registered).
  - Minimum transaction is 2 cycles: grant edge, then the response cycle.
- **Response:** passthrough, zero-cycle latency from `mem_response`. Arbitration resumes on the edge after the response, so back-to-back transactions are 1 cycle apart.
- **Data master holding its request through the response cycle:** this is legal. The arbiter re-samples in `IDLE` on the following cycle; the core's registered strobes then reflect the next instruction.
- **Async reset mid-transaction:**
  - Strobes drop immediately.
  - No response is generated.
  - The pending master must reissue.

## Structure
- **Package `bus_arbiter_pkg`:**
  - `arb_state_t` (`IDLE`/`INSTR`/`DATA`, 2 bits);
  - `OWNER_INSTR`/`OWNER_DATA` encodings;
  - the default `STARVE_LIMIT`/`TIMEOUT` constants.
- **Sub-module `arb_watchdog`:**
  - parameterized down-counter;
  - inputs `clk`, `reset`, `start`, `active`;
  - output `expired`.
- The top level holds the FSM, latches, starve counter and response gating. Roughly 200 lines total.

## Test plan
- **Single data load:** `data_memory_read`=1, `data_address`=0x100; memory responds 3 cycles later with 0xDEADBEEF → `mem_read`=1, `mem_address`=0x100 from the grant edge; `data_memory_response` and `read_data`=0xDEADBEEF in the same cycle as `mem_response`; `instruction_response` stays 0.
- **Fetch during store:** `data_memory_write` and `instruction_request` both held, `STARVE_LIMIT`=4, memory responds in 1 cycle → four data grants, then one instruction grant, then data again; starve counter returns to 0.
- **Read and write together:** `data_memory_read`=`data_memory_write`=1 → only `mem_write`=1, with `mem_write_data`=`write_data`.
- **Hung memory:** `TIMEOUT`=8, `mem_response` never asserted → owner response pulses on cycle 8 with data 0; `bus_error` rises and stays 1; the next request is granted normally.
- **Reset mid-transaction:** drop `reset` low during `DATA` → `mem_read`/`mem_write` go 0 asynchronously, no response pulses, state `IDLE` after release.
- **Spurious response:** `mem_response` pulsed in `IDLE` → no response outputs, state unchanged.
